// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: frame sequencer for the serial-in / parallel-encode / serial-out message path.
// Fills the SIPO with K message bits, pulses the parallel load, then walks the encoder through
// NSEG segments with a valid/ready handshake, and finally drives a K-cycle transmit shift.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start, abort    begin a frame (IDLE only) / return to IDLE from any state
//   sm_in, sm       mode select input (latched on accepted start) / registered mode
//   in_valid        serial bit present on the datapath input
//   in_ready        controller accepting bits (FILL only)
//   datavalid       SIPO enable, in_valid & in_ready
//   load_en         one-cycle parallel capture into PIPO/PISO
//   f_sel           segment index to the data mux
//   seg_valid       segment valid for the encoder; seg_ready is the encoder accept
//   tx_shift        PISO shift enable; tx_last marks the final transmit cycle
//   busy            controller not in IDLE
//   frame_done      one-cycle completion pulse
module spi_frame_ctrl #(
  parameter int unsigned K    = 1024,
  parameter int unsigned Lm   = 16,
  parameter int unsigned La   = 8,
  parameter int unsigned M    = 32,
  parameter int unsigned NSEG = K / (M * La),
  parameter int unsigned CW   = $clog2(K + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sm_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       datavalid,
  output logic       load_en,
  output logic       sm,
  output logic [1:0] f_sel,
  output logic       seg_valid,
  input  logic       seg_ready,
  output logic       tx_shift,
  output logic       tx_last,
  output logic       busy,
  output logic       frame_done
);

  // Elaboration-time parameter consistency checks.
  if ((K % (M * La)) != 0) begin : g_bad_k
    $error("spi_frame_ctrl: K must be a multiple of M*La");
  end
  if ((NSEG == 0) || (NSEG > 4) || (NSEG != K / (M * La))) begin : g_bad_nseg
    $error("spi_frame_ctrl: NSEG must equal K/(M*La) and lie in 1..4");
  end
  if (Lm == 0) begin : g_bad_lm
    $error("spi_frame_ctrl: Lm must be non-zero");
  end

  localparam logic [CW-1:0] KLast   = CW'(K - 1);
  localparam logic [1:0]    SegLast = 2'(NSEG - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StLoad,
    StEnc,
    StTx,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]    seg_idx_q, seg_idx_d;
  logic          sm_q, sm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      seg_idx_q <= '0;
      sm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      seg_idx_q <= seg_idx_d;
      sm_q      <= sm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    seg_idx_d  = seg_idx_q;
    sm_d       = sm_q;
    in_ready   = 1'b0;
    load_en    = 1'b0;
    f_sel      = 2'd0;
    seg_valid  = 1'b0;
    tx_shift   = 1'b0;
    tx_last    = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort in the same cycle as start keeps the controller idle
        if (start && !abort) begin
          state_d   = StFill;
          sm_d      = sm_in;
          bit_cnt_d = '0;
          seg_idx_d = '0;
        end
      end
      StFill: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == KLast) begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        load_en   = 1'b1;
        seg_idx_d = '0;
        state_d   = StEnc;
      end
      StEnc: begin
        seg_valid = 1'b1;
        f_sel     = seg_idx_q;
        if (seg_ready) begin
          if (seg_idx_q == SegLast) begin
            state_d   = StTx;
            bit_cnt_d = '0;
          end else begin
            seg_idx_d = seg_idx_q + 2'd1;
          end
        end
      end
      StTx: begin
        tx_shift = 1'b1;
        if (bit_cnt_q == KLast) begin
          tx_last = 1'b1;
          state_d = StDone;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides every transition; sm keeps its latched value.
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      seg_idx_d = '0;
    end
  end

  assign datavalid = in_valid & in_ready;
  assign sm        = sm_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Testbench for spi_frame_ctrl. The driver applies randomized stimulus and, from the frame rules
// (fill K accepted bits, load, NSEG handshakes, K transmit cycles, done), pushes each expected
// output event with its cycle stamp into a queue. An independent monitor detects events on the
// DUT outputs and pops/compares them.
module tb_spi_frame_ctrl;

  localparam int K    = 1024;
  localparam int NSEG = 4;

  localparam int EvStr  = 0;
  localparam int EvLoad = 1;
  localparam int EvSeg  = 2;
  localparam int EvTxf  = 3;
  localparam int EvTxl  = 4;
  localparam int EvDone = 5;
  localparam int EvAbt  = 6;

  typedef struct {
    int k;
    int c;
    int a;
    int b;
    int s;
    int l;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, sm_in, in_valid, seg_ready;
  logic       in_ready, datavalid, load_en, sm, seg_valid, tx_shift, tx_last, busy, frame_done;
  logic [1:0] f_sel;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  ev_t q[$];

  spi_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .sm_in      (sm_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .datavalid  (datavalid),
    .load_en    (load_en),
    .sm         (sm),
    .f_sel      (f_sel),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .tx_shift   (tx_shift),
    .tx_last    (tx_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver / reference model ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(int k, int a = 0, int b = 0, int s = 0, int l = 0);
    ev_t e;
    e.k = k; e.c = cyc; e.a = a; e.b = b; e.s = s; e.l = l;
    q.push_back(e);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      start = 1'b0;
      abort = 1'b0;
      in_valid = 1'($urandom_range(1));
      seg_ready = 1'($urandom_range(1));
      tick();
    end
  endtask

  task automatic run_frame(input int pv, input bit toggle, input int pr, input bit bp2,
                           input int abort_at, input bit rst_tx, input bit nominal);
    int s, n, idx, hold, m_sm;
    m_sm = int'($urandom_range(1));
    sm_in = 1'(m_sm);
    start = 1'b1;
    abort = 1'b0;
    s = cyc;
    tick();
    start = 1'b0;
    sm_in = ~sm_in;  // must not affect the latched mode
    push(EvStr);
    n = 0;
    while (n < K) begin
      if (toggle) in_valid = 1'(((cyc - s) % 2) == 1);
      else in_valid = 1'($urandom_range(99) < pv);
      start = 1'($urandom_range(15) == 0);
      seg_ready = 1'($urandom_range(1));
      if (in_valid) n++;
      tick();
    end
    in_valid = 1'($urandom_range(1));
    start = 1'($urandom_range(1));
    push(EvLoad);
    tick();
    idx = 0;
    hold = 0;
    while (idx < NSEG) begin
      start = 1'($urandom_range(3) == 0);
      in_valid = 1'($urandom_range(1));
      if (abort_at == idx) begin
        seg_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        push(EvAbt);
        return;
      end
      if (bp2 && idx == 2 && hold < 5) begin
        seg_ready = 1'b0;
        hold++;
      end else if (bp2) begin
        seg_ready = 1'b1;
      end else begin
        seg_ready = 1'($urandom_range(99) < pr);
      end
      if (seg_ready) begin
        push(EvSeg, idx);
        idx++;
      end
      tick();
    end
    push(EvTxf);
    for (int i = 0; i < K; i++) begin
      start = 1'($urandom_range(15) == 0);
      in_valid = 1'($urandom_range(1));
      seg_ready = 1'($urandom_range(1));
      if (i == K - 1) push(EvTxl);
      if (rst_tx && i == 200) begin
        rst = 1'b1;
        push(EvAbt);
        tick();
        tick();
        tick();
        rst = 1'b0;
        return;
      end
      tick();
    end
    push(EvDone, K, K, m_sm, nominal ? (1 + K + 1 + NSEG + K + 1) : (cyc - s + 1));
    start = 1'b1;  // start in DONE must be ignored
    tick();
    start = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   dv_cnt = 0;
  int   tx_cnt = 0;
  int   start_cyc = 0;
  logic p_busy = 1'b0;
  logic p_done = 1'b0;
  logic p_tx = 1'b0;
  logic p_hold = 1'b0;
  logic [1:0] p_fsel = 2'd0;

  task automatic got(input int k, input int a, input int b, input int s, input int l);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got k=%0d c=%0d a=%0d b=%0d s=%0d l=%0d, required none",
               k, cyc, a, b, s, l);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.c != cyc || e.a != a || e.b != b || e.s != s || e.l != l) begin
        bad++;
        $display("FAIL event: got k=%0d c=%0d a=%0d b=%0d s=%0d l=%0d, required k=%0d c=%0d a=%0d b=%0d s=%0d l=%0d",
                 k, cyc, a, b, s, l, e.k, e.c, e.a, e.b, e.s, e.l);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!busy && p_busy && !p_done) got(EvAbt, 0, 0, 0, 0);
    if (rst) begin
      total++;
      if ({in_ready, datavalid, load_en, sm, f_sel, seg_valid, tx_shift, tx_last, busy,
           frame_done} !== 11'd0) begin
        bad++;
        $display("FAIL reset_outputs: got %b, required all zero",
                 {in_ready, datavalid, load_en, sm, f_sel, seg_valid, tx_shift, tx_last, busy,
                  frame_done});
      end
      p_hold = 1'b0;
    end else begin
      total++;
      if (datavalid !== (in_valid & in_ready)) begin
        bad++;
        $display("FAIL datavalid: got %b, required %b", datavalid, in_valid & in_ready);
      end
      if (p_hold) begin
        total++;
        if (seg_valid !== 1'b1 || f_sel !== p_fsel) begin
          bad++;
          $display("FAIL seg_stable: got valid=%b f_sel=%0d, required valid=1 f_sel=%0d",
                   seg_valid, f_sel, p_fsel);
        end
      end
      if (busy && !p_busy) begin
        start_cyc = cyc - 1;
        got(EvStr, 0, 0, 0, 0);
      end
      if (load_en) got(EvLoad, 0, 0, 0, 0);
      if (seg_valid && seg_ready) got(EvSeg, int'(f_sel), 0, 0, 0);
      if (tx_shift && !p_tx) got(EvTxf, 0, 0, 0, 0);
      if (tx_last) got(EvTxl, 0, 0, 0, 0);
      if (datavalid) dv_cnt++;
      if (tx_shift) tx_cnt++;
      if (frame_done) got(EvDone, dv_cnt, tx_cnt, int'(sm), cyc - start_cyc + 1);
      p_hold = seg_valid && !seg_ready && !abort;
    end
    if (!busy) begin
      dv_cnt = 0;
      tx_cnt = 0;
    end
    p_busy = busy;
    p_done = frame_done;
    p_tx = tx_shift;
    p_fsel = f_sel;
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sm_in = 1'b0;
    in_valid = 1'b0;
    seg_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    idle(3);
    run_frame(100, 0, 100, 0, -1, 0, 1);  // nominal full-speed frame
    idle(4);
    run_frame(0, 1, 100, 0, -1, 0, 0);    // 1010... input gaps
    idle(3);
    run_frame(100, 0, 100, 1, -1, 0, 0);  // backpressure on segment 2
    idle(3);
    run_frame(100, 0, 100, 0, 1, 0, 0);   // abort at seg_idx 1
    idle(2);
    start = 1'b1;                         // start+abort in IDLE: stay idle
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    idle(3);
    run_frame(70, 0, 60, 0, -1, 1, 0);    // reset mid-TX
    idle(3);
    run_frame(100, 0, 100, 0, -1, 0, 1);  // full frame after reset
    repeat (3) begin
      run_frame(60 + int'($urandom_range(40)), 0, 40 + int'($urandom_range(60)), 0, -1, 0, 0);
      idle(int'($urandom_range(4, 1)));
    end
    idle(3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
